// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 Hz timing generator: 25 MHz pixel strobe from gen_clk, h/v counters and sync decode.
// Optional output frame_start is built only when VGA_FRAME_START_EN is defined.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       gen_clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       p_tick
`ifdef VGA_FRAME_START_EN
  ,
  output logic       frame_start
`endif
);

  // Both totals must stay within 1024 so the 10-bit counters never overflow.
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic       div;
  logic       run;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // div goes high on the first edge out of reset, so pixel (0,0) gets a single-cycle strobe.
  always_ff @(posedge gen_clk) begin
    if (!reset) begin
      div   <= 1'b0;
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      div <= ~div;
      if (div) begin
        if (h_end) begin
          h_cnt <= '0;
          v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Outputs decode registers only, so they all move together on the counter edge.
  always_comb begin
    p_tick   = div;
    pixel_x  = h_cnt;
    pixel_y  = v_cnt;
    hsync    = ~(run && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vsync    = ~(run && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    video_on = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

`ifdef VGA_FRAME_START_EN
  assign frame_start = div && h_end && v_end;
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 Hz timing generator for the 50 MHz `gen_clk` domain. It divides `gen_clk` into a 25 MHz pixel-enable strobe and runs the horizontal and vertical counters. From those counters it produces active-low `hsync`/`vsync`, a display-area flag and the current pixel coordinates. It sits directly upstream of the pixel/colour stage in `Main`, which consumes `video_on`, `pixel_x`, `pixel_y` and `p_tick` to drive `rgb[2:0]`.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `gen_clk`  in  1  system clock, 50 MHz; one clock domain, all state on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while the current pixel is in the visible area
- `pixel_x`  out  10  current horizontal count, 0..H_TOTAL-1
- `pixel_y`  out  10  current vertical count, 0..V_TOTAL-1
- `p_tick`  out  1  pixel-enable strobe, high on every second `gen_clk` cycle
- `frame_start`  out  1  present only with `VGA_FRAME_START_EN`

## Operation
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
  - Both totals must be ≤1024. Counters are 10 bits and never exceed TOTAL-1.
- Registers:
  - `div`: 1 bit.
  - `run`: 1 bit.
  - `h_cnt`: 10 bits.
  - `v_cnt`: 10 bits.
- Reset (`reset`=0 at an edge):
  - `div`=0, `run`=0, `h_cnt`=0, `v_cnt`=0.
  - Resulting outputs: `hsync`=1, `vsync`=1, `video_on`=0, `pixel_x`=0, `pixel_y`=0, `p_tick`=0, `frame_start`=0.
- Run (`reset`=1):
  - `run`<=1.
  - `div`<=~`div`.
  - `p_tick` = `div` (combinational from the register).
- Counter update on an edge with `p_tick`=1:
  - if `h_cnt`==H_TOTAL-1: `h_cnt`<=0, and `v_cnt`<=(`v_cnt`==V_TOTAL-1) ? 0 : `v_cnt`+1;
  - else `h_cnt`<=`h_cnt`+1 and `v_cnt` holds.
- Output decode (combinational from registers only; no input feeds an output combinationally):
  - `hsync` = ~(`run` & `h_cnt` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]), i.e. low for 656..751.
  - `vsync` = ~(`run` & `v_cnt` in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1]), i.e. low for 490..491.
  - `video_on` = `run` & (`h_cnt`<H_DISPLAY) & (`v_cnt`<V_DISPLAY).
  - `pixel_x`=`h_cnt`, `pixel_y`=`v_cnt`.
- Reset mid-frame: on the next edge all registers return to their reset values, with no partial-line completion.

## Timing
- E1 is the first edge with `reset`=1. It sets `run`=1 and `div`=1, so pixel (0,0) is visible with `p_tick`=1 for one cycle.
- From E1 on:
  - `h_cnt` advances on E2, E4, E6, …
  - every pixel after (0,0) lasts exactly 2 `gen_clk` cycles.
- Line period: 1600 cycles.
- `hsync` low pulse: 192 cycles.
- Frame period: 840000 cycles.
- `vsync` low pulse: 3200 cycles.
- All output changes coincide with the counter edge, so `hsync`, `vsync` and `video_on` share the same alignment as `pixel_x`/`pixel_y`.

## Configuration
- `VGA_FRAME_START_EN` defined:
  - adds output `frame_start` (1 bit) = `p_tick` & (`h_cnt`==H_TOTAL-1) & (`v_cnt`==V_TOTAL-1);
  - one `gen_clk` cycle wide, once per frame, during the last pixel;
  - 0 while in reset.
- Not defined: the port and logic are absent; all other behaviour is identical.

## Test plan
- Hold `reset`=0 for 5 cycles → `hsync`=1, `vsync`=1, `video_on`=0, `pixel_x`=0, `pixel_y`=0, `p_tick`=0 throughout.
- Release reset → after E1, `p_tick` alternates 1,0,1,…; `pixel_x` steps 0→1 at E2 and 1→2 at E4; `video_on`=1 from E1.
- Run one line → `hsync` falls when `pixel_x`=656 and rises at 752, low for 192 cycles; `video_on` falls at `pixel_x`=640; `pixel_x` wraps 799→0 while `pixel_y` steps 0→1.
- Run a full frame → `vsync` low exactly while `pixel_y` is 490..491 (3200 cycles); period between `vsync` falling edges = 840000 cycles; `pixel_y` wraps 524→0.
- Assert `reset`=0 for one edge at `pixel_x`=300, `pixel_y`=200 → next cycle all outputs at reset values; after release, timing restarts as in scenario 2.
- With `VGA_FRAME_START_EN` → `frame_start` high for exactly one cycle at `pixel_x`=799, `pixel_y`=524; pulses 840000 cycles apart; never high in reset.
